// File: rtl/usb_tx_counter_pkg.sv
// Shared types and constants for the multi-channel USB TX counter.
// Channel slices are packed with channel 0 in the LSBs.
package usb_tx_counter_pkg;

  typedef enum logic {
    MODE_WRAP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } cnt_mode_e;

  localparam int unsigned SIZE_DEF   = 10;
  localparam int unsigned INC_W_DEF  = 8;
  localparam int unsigned NUM_CH_DEF = 2;

  function automatic int unsigned ch_lsb(
    input int unsigned ch,
    input int unsigned w
  );
    return ch * w;
  endfunction

endpackage

// File: rtl/usb_tx_counter_ch.sv
// One counter channel: step, terminal compare, wrap residue, one-shot done.
// Priority is clear > load > enable > hold; all outputs registered.
module usb_tx_counter_ch
  import usb_tx_counter_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEF,
  parameter int unsigned INC_W = INC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [SIZE-1:0]  load_val_i,
  input  logic [INC_W-1:0] inc_val_i,
  input  logic [SIZE-1:0]  roll_val_i,
  input  cnt_mode_e        mode_i,
  output logic [SIZE-1:0]  count_o,
  output logic             pulse_o,
  output logic             done_o
);

  localparam int unsigned W1 = SIZE + 1;

  logic [SIZE-1:0] count_q, count_d;
  logic            pulse_q, pulse_d;
  logic            done_q, done_d;
  logic [W1-1:0]   sum, roll_ext, residue;
  logic            roll_nz, hit, frozen;

  always_comb begin
    roll_ext = W1'(roll_val_i);
    sum      = W1'(count_q) + W1'(inc_val_i);
    residue  = sum - roll_ext;
    roll_nz  = |roll_val_i;
    hit      = roll_nz && (sum >= roll_ext);
    frozen   = (mode_i == MODE_ONESHOT) && done_q;
    count_d  = count_q;
    pulse_d  = 1'b0;
    done_d   = done_q;
    if (clear_i) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (load_i) begin
      count_d = load_val_i;
      done_d  = 1'b0;
    end else if (en_i && roll_nz && !frozen) begin
      if (!hit) begin
        count_d = sum[SIZE-1:0];
      end else if (mode_i == MODE_ONESHOT) begin
        count_d = roll_val_i;
        done_d  = 1'b1;
        pulse_d = 1'b1;
      end else begin
        // A step larger than the period can overshoot twice; park at 0
        count_d = (residue < roll_ext) ? residue[SIZE-1:0] : '0;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign pulse_o = pulse_q;
  assign done_o  = done_q;

endmodule

// File: rtl/usb_tx_multi_counter.sv
// Multi-channel TX timing counter: packs and unpacks per-channel buses
// around NUM_CH independent usb_tx_counter_ch instances.
module usb_tx_multi_counter
  import usb_tx_counter_pkg::*;
#(
  parameter int unsigned SIZE   = SIZE_DEF,
  parameter int unsigned INC_W  = INC_W_DEF,
  parameter int unsigned NUM_CH = NUM_CH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       count_enable,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*SIZE-1:0]  load_val,
  input  logic [NUM_CH*INC_W-1:0] inc_val,
  input  logic [NUM_CH*SIZE-1:0]  rollover_val,
  input  logic [NUM_CH-1:0]       oneshot,
  output logic [NUM_CH*SIZE-1:0]  count_out,
  output logic [NUM_CH-1:0]       rollover_pulse,
  output logic [NUM_CH-1:0]       done
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int unsigned LS = ch_lsb(g, SIZE);
    localparam int unsigned LI = ch_lsb(g, INC_W);

    usb_tx_counter_ch #(
      .SIZE  (SIZE),
      .INC_W (INC_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear[g]),
      .en_i       (count_enable[g]),
      .load_i     (load[g]),
      .load_val_i (load_val[LS +: SIZE]),
      .inc_val_i  (inc_val[LI +: INC_W]),
      .roll_val_i (rollover_val[LS +: SIZE]),
      .mode_i     (cnt_mode_e'(oneshot[g])),
      .count_o    (count_out[LS +: SIZE]),
      .pulse_o    (rollover_pulse[g]),
      .done_o     (done[g])
    );
  end

endmodule

// File: tb/tb_usb_tx_multi_counter.sv
// Directed self-checking bench for usb_tx_multi_counter (2 ch, SIZE 10).
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_usb_tx_multi_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  clear, count_enable, load, oneshot;
  logic [19:0] load_val, rollover_val, count_out;
  logic [15:0] inc_val;
  logic [1:0]  rollover_pulse, done;

  int n_checks = 0;
  int n_fail   = 0;

  usb_tx_multi_counter #(
    .SIZE   (10),
    .INC_W  (8),
    .NUM_CH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .count_enable   (count_enable),
    .load           (load),
    .load_val       (load_val),
    .inc_val        (inc_val),
    .rollover_val   (rollover_val),
    .oneshot        (oneshot),
    .count_out      (count_out),
    .rollover_pulse (rollover_pulse),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({count_out, rollover_pulse, done} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_init: got cnt=%h pls=%b done=%b want 0",
               count_out, rollover_pulse, done);
    end
    tick();
    rst = 1'b0;
    inc_val[7:0]      = 8'd8;
    rollover_val[9:0] = 10'd544;
    count_enable      = 2'b01;
    tick(); tick(); tick();
    n_checks++;
    if (count_out[9:0] !== 10'd24) begin
      n_fail++;
      $display("FAIL reset_precount: got %0d want 24", count_out[9:0]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({count_out, rollover_pulse, done} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_async: got cnt=%h pls=%b done=%b want 0",
               count_out, rollover_pulse, done);
    end
    #1 rst = 1'b0;
    tick();
    n_checks++;
    if (count_out[9:0] !== 10'd8) begin
      n_fail++;
      $display("FAIL reset_resume: got %0d want 8", count_out[9:0]);
    end
    count_enable = 2'b00;
  endtask

  task automatic test_wrap_ch0();
    int exp_c;
    clear = 2'b01;
    tick();
    clear = 2'b00;
    inc_val[7:0]      = 8'd8;
    rollover_val[9:0] = 10'd544;
    oneshot[0]        = 1'b0;
    count_enable      = 2'b01;
    for (int i = 1; i <= 69; i++) begin
      tick();
      exp_c = (i < 68) ? 8 * i : (i == 68 ? 0 : 8);
      n_checks++;
      if (count_out[9:0] !== 10'(exp_c) ||
          rollover_pulse[0] !== (i == 68)) begin
        n_fail++;
        $display("FAIL wrap0 en%0d: got cnt=%0d pls=%b want cnt=%0d pls=%b",
                 i, count_out[9:0], rollover_pulse[0], exp_c, (i == 68));
      end
    end
    count_enable = 2'b00;
  endtask

  task automatic test_wrap_ch1();
    int exp_c[6] = '{7, 14, 1, 8, 15, 2};
    bit exp_p[6] = '{0, 0, 1, 0, 0, 1};
    clear = 2'b10;
    tick();
    clear = 2'b00;
    inc_val[15:8]       = 8'd7;
    rollover_val[19:10] = 10'd20;
    oneshot[1]          = 1'b0;
    count_enable        = 2'b10;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (count_out[19:10] !== 10'(exp_c[i]) ||
          rollover_pulse[1] !== exp_p[i]) begin
        n_fail++;
        $display("FAIL wrap1 en%0d: got cnt=%0d pls=%b want cnt=%0d pls=%b",
                 i + 1, count_out[19:10], rollover_pulse[1],
                 exp_c[i], exp_p[i]);
      end
    end
    count_enable = 2'b00;
  endtask

  task automatic test_oneshot();
    int exp_c[5] = '{4, 8, 10, 10, 10};
    bit exp_p[5] = '{0, 0, 1, 0, 0};
    bit exp_d[5] = '{0, 0, 1, 1, 1};
    clear = 2'b01;
    tick();
    clear = 2'b00;
    inc_val[7:0]      = 8'd4;
    rollover_val[9:0] = 10'd10;
    oneshot[0]        = 1'b1;
    count_enable      = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (count_out[9:0] !== 10'(exp_c[i]) ||
          rollover_pulse[0] !== exp_p[i] || done[0] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL oneshot en%0d: got cnt=%0d pls=%b done=%b want %0d %b %b",
                 i + 1, count_out[9:0], rollover_pulse[0], done[0],
                 exp_c[i], exp_p[i], exp_d[i]);
      end
    end
    count_enable  = 2'b00;
    load          = 2'b01;
    load_val[9:0] = 10'd3;
    tick();
    load = 2'b00;
    n_checks++;
    if (count_out[9:0] !== 10'd3 || done[0] !== 1'b0 ||
        rollover_pulse[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_load: got cnt=%0d done=%b pls=%b want 3 0 0",
               count_out[9:0], done[0], rollover_pulse[0]);
    end
    oneshot[0] = 1'b0;
  endtask

  task automatic test_priority();
    inc_val[7:0]      = 8'd4;
    rollover_val[9:0] = 10'd10;
    load_val[9:0]     = 10'd9;
    clear             = 2'b01;
    load              = 2'b01;
    count_enable      = 2'b01;
    tick();
    n_checks++;
    if (count_out[9:0] !== 10'd0) begin
      n_fail++;
      $display("FAIL prio_clear: got %0d want 0", count_out[9:0]);
    end
    clear = 2'b00;
    tick();
    n_checks++;
    if (count_out[9:0] !== 10'd9 || rollover_pulse[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_load: got cnt=%0d pls=%b want 9 0",
               count_out[9:0], rollover_pulse[0]);
    end
    load                = 2'b10;
    count_enable        = 2'b00;
    load_val[19:10]     = 10'd15;
    inc_val[15:8]       = 8'd7;
    rollover_val[19:10] = 10'd20;
    tick();
    load         = 2'b00;
    clear        = 2'b01;
    count_enable = 2'b11;
    tick();
    clear        = 2'b00;
    count_enable = 2'b00;
    n_checks++;
    if (count_out[9:0] !== 10'd0 || count_out[19:10] !== 10'd2 ||
        rollover_pulse !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_indep: got c0=%0d c1=%0d pls=%b want 0 2 10",
               count_out[9:0], count_out[19:10], rollover_pulse);
    end
  endtask

  task automatic test_boundary();
    load          = 2'b01;
    load_val[9:0] = 10'd7;
    tick();
    load              = 2'b00;
    rollover_val[9:0] = 10'd0;
    inc_val[7:0]      = 8'd5;
    count_enable      = 2'b01;
    tick();
    n_checks++;
    if (count_out[9:0] !== 10'd7 || rollover_pulse[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL roll_zero: got cnt=%0d pls=%b want 7 0",
               count_out[9:0], rollover_pulse[0]);
    end
    count_enable      = 2'b00;
    load              = 2'b01;
    load_val[9:0]     = 10'd15;
    rollover_val[9:0] = 10'd20;
    tick();
    load              = 2'b00;
    rollover_val[9:0] = 10'd6;
    inc_val[7:0]      = 8'd0;
    count_enable      = 2'b01;
    tick();
    count_enable = 2'b00;
    n_checks++;
    if (count_out[9:0] !== 10'd0 || rollover_pulse[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL roll_lower: got cnt=%0d pls=%b want 0 1",
               count_out[9:0], rollover_pulse[0]);
    end
    tick();
    n_checks++;
    if (rollover_pulse[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL roll_lower_pulse_end: got %b want 0", rollover_pulse[0]);
    end
  endtask

  initial begin
    rst          = 1'b0;
    clear        = '0;
    count_enable = '0;
    load         = '0;
    oneshot      = '0;
    load_val     = '0;
    inc_val      = '0;
    rollover_val = '0;
    test_reset();
    test_wrap_ch0();
    test_wrap_ch1();
    test_oneshot();
    test_priority();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
